// File: rtl/clear_req_merge_pkg.sv
// Shared definitions for the data-queue clear request merger.
// Queue geometry, the clear request type and the modular pointer helper.
package clear_req_merge_pkg;

    localparam int CRM_DEPTH         = 30;
    localparam int CRM_IW            = $clog2(CRM_DEPTH);
    localparam int CRM_WB_NUM        = 6;
    localparam int CRM_CLEARPORT_NUM = 4;
    localparam int CRM_BUF_DEPTH     = 16;

    typedef struct packed {
        logic [CRM_IW-1:0] dqIdx;
    } clear_req_t;

    // Advance a circular pointer by n (n <= size) without a modulo operator.
    function automatic int wrap_add(input int ptr, input int n, input int size);
        return (ptr + n < size) ? ptr + n : ptr + n - size;
    endfunction

endpackage

// File: rtl/clear_req_merge_compact.sv
// req_compact: packs the set valid lanes toward lane 0 in port order.
// Also reports how many lanes were set.
module req_compact
    import clear_req_merge_pkg::*;
#(
    parameter int N = CRM_WB_NUM,
    localparam int CNTW = $clog2(N + 1)
) (
    input  logic [N-1:0]             i_vld,
    input  logic [N-1:0][CRM_IW-1:0] i_data,
    output logic [N-1:0]             o_vld,
    output logic [N-1:0][CRM_IW-1:0] o_data,
    output logic [CNTW-1:0]          o_cnt
);

    logic [CNTW-1:0] pos;

    // Walk lanes lowest first, dropping each valid one into the next free slot.
    always_comb begin
        o_data = '0;
        o_vld  = '0;
        pos    = '0;
        for (int i = 0; i < N; i++) begin
            if (i_vld[i]) begin
                o_data[pos] = i_data[i];
                pos         = pos + CNTW'(1);
            end
        end
        for (int i = 0; i < N; i++) begin
            o_vld[i] = (int'(pos) > i);
        end
        o_cnt = pos;
    end

endmodule

// File: rtl/clear_req_merge.sv
// clear_req_merge: merges writeback completions onto the clear ports,
// buffering any surplus. Optional same-cycle bypass: CLEAR_BYPASS_EN.
module clear_req_merge
    import clear_req_merge_pkg::*;
#(
    parameter int WB_NUM        = CRM_WB_NUM,
    parameter int CLEARPORT_NUM = CRM_CLEARPORT_NUM,
    parameter int BUF_DEPTH     = CRM_BUF_DEPTH,
    localparam int IW   = CRM_IW,
    localparam int PW   = $clog2(BUF_DEPTH),
    localparam int CW   = $clog2(BUF_DEPTH + 1),
    localparam int SW   = (WB_NUM > 1) ? $clog2(WB_NUM) : 1,
    localparam int NCW  = $clog2(WB_NUM + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_flush,
    output logic                              o_wb_ready,
    input  logic [WB_NUM-1:0]                 i_wb_vld,
    input  logic [WB_NUM-1:0][IW-1:0]         i_wb_dqIdx,
    output logic [CLEARPORT_NUM-1:0]          o_clear_vld,
    output logic [CLEARPORT_NUM-1:0][IW-1:0]  o_clear_dqIdx,
    output logic [CW-1:0]                     o_pending
);

    localparam int READY_MAX = BUF_DEPTH - WB_NUM;

    clear_req_t     buf_q [BUF_DEPTH];
    logic [PW-1:0]  head_q;
    logic [PW-1:0]  tail_q;
    logic [CW-1:0]  count_q;

    logic                     take;
    logic [WB_NUM-1:0]        in_vld;
    logic [WB_NUM-1:0]        c_vld;
    logic [WB_NUM-1:0]        enq_vld;
    logic [WB_NUM-1:0][IW-1:0] c_data;
    logic [NCW-1:0]           c_cnt;
    logic [PW-1:0]            rd_ptr [CLEARPORT_NUM];
    logic [PW-1:0]            wr_ptr [WB_NUM];
    int                       deq;
    int                       byp;
    int                       enq;
    logic                     dup;

    assign o_wb_ready = (count_q <= CW'(READY_MAX));
    assign o_pending  = count_q;
    assign take       = o_wb_ready && !i_flush;
    assign in_vld     = take ? i_wb_vld : '0;

    req_compact #(.N(WB_NUM)) u_compact (
        .i_vld  (in_vld),
        .i_data (i_wb_dqIdx),
        .o_vld  (c_vld),
        .o_data (c_data),
        .o_cnt  (c_cnt)
    );

    // Circular read/write addresses for every drain slot and enqueue slot.
    always_comb begin
        for (int k = 0; k < CLEARPORT_NUM; k++) begin
            rd_ptr[k] = PW'(wrap_add(int'(head_q), k, BUF_DEPTH));
        end
        for (int j = 0; j < WB_NUM; j++) begin
            wr_ptr[j] = PW'(wrap_add(int'(tail_q), j, BUF_DEPTH));
        end
    end

    // Drain oldest entries first, then (bypass builds) fill free slots with new events.
    always_comb begin
        deq = 0;
        byp = 0;
        if (!i_flush) begin
            deq = (int'(count_q) < CLEARPORT_NUM) ? int'(count_q) : CLEARPORT_NUM;
        end
`ifdef CLEAR_BYPASS_EN
        if (take) begin
            byp = (int'(c_cnt) < CLEARPORT_NUM - deq) ? int'(c_cnt)
                                                      : CLEARPORT_NUM - deq;
        end
`endif
        enq     = int'(c_cnt) - byp;
        enq_vld = c_vld >> byp;
        for (int k = 0; k < CLEARPORT_NUM; k++) begin
            o_clear_vld[k]   = 1'b0;
            o_clear_dqIdx[k] = '0;
            if (k < deq) begin
                o_clear_vld[k]   = 1'b1;
                o_clear_dqIdx[k] = buf_q[rd_ptr[k]].dqIdx;
            end
`ifdef CLEAR_BYPASS_EN
            else if (k < deq + byp) begin
                o_clear_vld[k]   = c_vld[SW'(k - deq)];
                o_clear_dqIdx[k] = c_data[SW'(k - deq)];
            end
`endif
        end
    end

    // Pointer and occupancy update; flush and reset both empty the buffer.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= PW'(wrap_add(int'(head_q), deq, BUF_DEPTH));
            tail_q  <= PW'(wrap_add(int'(tail_q), enq, BUF_DEPTH));
            count_q <= CW'(int'(count_q) + enq - deq);
        end
    end

    // Store events that did not leave this cycle at tail onward.
    always_ff @(posedge clk) begin
        if (!rst && !i_flush) begin
            for (int j = 0; j < WB_NUM; j++) begin
                if (enq_vld[j]) begin
                    buf_q[wr_ptr[j]] <= '{dqIdx: c_data[SW'(byp + j)]};
                end
            end
        end
    end

    // Detect a repeated index among the lanes accepted this cycle.
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < WB_NUM; i++) begin
            for (int j = i + 1; j < WB_NUM; j++) begin
                if (in_vld[i] && in_vld[j] && i_wb_dqIdx[i] == i_wb_dqIdx[j]) begin
                    dup = 1'b1;
                end
            end
        end
    end

    // Protocol and occupancy invariants.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!((|i_wb_vld) && !o_wb_ready && !i_flush));
            assert (!dup);
            assert (count_q <= CW'(BUF_DEPTH));
        end
    end

endmodule

// File: tb/tb_clear_req_merge.sv
// Bench for clear_req_merge: queue-based model checked every cycle
// plus hand-computed expectations from the directed scenarios.
module tb_clear_req_merge;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 i_flush = 1'b0;
    logic                 o_wb_ready;
    logic [5:0]           wb_vld = '0;
    logic [5:0][4:0]      wb_idx = '0;
    logic [3:0]           o_clear_vld;
    logic [3:0][4:0]      o_clear_dqIdx;
    logic [4:0]           o_pending;

    int npass = 0;
    int ntot  = 0;
    int q[$];

    logic [3:0]      obs_vld;
    logic [3:0][4:0] obs_idx;
    int              obs_pend;
    int              obs_rdy;

    clear_req_merge dut (
        .clk           (clk),
        .rst           (rst),
        .i_flush       (i_flush),
        .o_wb_ready    (o_wb_ready),
        .i_wb_vld      (wb_vld),
        .i_wb_dqIdx    (wb_idx),
        .o_clear_vld   (o_clear_vld),
        .o_clear_dqIdx (o_clear_dqIdx),
        .o_pending     (o_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input int got, input int want);
        ntot++;
        if (got == want) npass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, want);
    endtask

    function automatic logic [5:0][4:0] mk6(input int b);
        logic [5:0][4:0] r;
        for (int p = 0; p < 6; p++) r[p] = 5'((b + p) % 30);
        return r;
    endfunction

    // One clock: drive inputs, compare against the queue model, advance it.
    task automatic cyc(input logic r, input logic fl,
                       input logic [5:0] v, input logic [5:0][4:0] ids);
        int n;
        int d;
        bit mr;
        int want[$];
        int inc[$];
        @(negedge clk);
        rst = r;
        i_flush = fl;
        wb_vld = v;
        wb_idx = ids;
        #1;
        obs_vld  = o_clear_vld;
        obs_idx  = o_clear_dqIdx;
        obs_pend = int'(o_pending);
        obs_rdy  = int'(o_wb_ready);
        for (int p = 0; p < 6; p++) if (v[p]) inc.push_back(int'(ids[p]));
        if (r) begin
            q.delete();
        end else begin
            n  = q.size();
            mr = (16 - n) >= 6;
            d  = 0;
            chk("pending", obs_pend, n);
            chk("ready", obs_rdy, int'(mr));
            if (!fl) begin
                d = (n < 4) ? n : 4;
                for (int k = 0; k < d; k++) want.push_back(q[k]);
`ifdef CLEAR_BYPASS_EN
                if (mr) begin
                    while (want.size() < 4 && inc.size() > 0)
                        want.push_back(inc.pop_front());
                end
`endif
            end
            chk("clear_vld", int'(obs_vld), (1 << want.size()) - 1);
            for (int k = 0; k < want.size(); k++)
                chk("clear_idx", int'(obs_idx[k]), want[k]);
            if (fl) begin
                q.delete();
            end else begin
                for (int k = 0; k < d; k++) void'(q.pop_front());
                if (mr) foreach (inc[i]) q.push_back(inc[i]);
            end
        end
        @(posedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 6'h00, '0);
    endtask

    task automatic drain(input string nm);
        int c;
        c = 0;
        while (q.size() > 0 && c < 20) begin
            idle();
            c++;
        end
        chk(nm, q.size(), 0);
    endtask

    initial begin
        logic [5:0][4:0] ids;
        bit seen_low;
        int base;

        // reset state
        cyc(1'b1, 1'b0, 6'h00, '0);
        cyc(1'b1, 1'b0, 6'h00, '0);
        idle();
        chk("rst_vld", int'(obs_vld), 0);
        chk("rst_pend", obs_pend, 0);
        chk("rst_rdy", obs_rdy, 1);

        // single event on port 2
        ids = '0;
        ids[2] = 5'd7;
        cyc(1'b0, 1'b0, 6'b000100, ids);
`ifdef CLEAR_BYPASS_EN
        chk("single_vld", int'(obs_vld), 1);
        chk("single_idx", int'(obs_idx[0]), 7);
`else
        chk("single_vld0", int'(obs_vld), 0);
        idle();
        chk("single_vld", int'(obs_vld), 1);
        chk("single_idx", int'(obs_idx[0]), 7);
`endif
        idle();

        // burst of six, indices 1..6
        cyc(1'b0, 1'b0, 6'h3F, mk6(1));
`ifdef CLEAR_BYPASS_EN
        chk("burst_vld0", int'(obs_vld), 4'hF);
        chk("burst_idx0", int'(obs_idx[0]), 1);
        chk("burst_idx3", int'(obs_idx[3]), 4);
`else
        chk("burst_pend0", obs_pend, 0);
        idle();
        chk("burst_pend6", obs_pend, 6);
        chk("burst_vld1", int'(obs_vld), 4'hF);
        chk("burst_idx0", int'(obs_idx[0]), 1);
        chk("burst_idx3", int'(obs_idx[3]), 4);
`endif
        idle();
        chk("burst_pend2", obs_pend, 2);
        chk("burst_vld2", int'(obs_vld), 4'h3);
        chk("burst_idx5", int'(obs_idx[0]), 5);
        chk("burst_idx6", int'(obs_idx[1]), 6);
        idle();
        chk("burst_pend_end", obs_pend, 0);

        // back-pressure: six per cycle while the model says ready
        seen_low = 1'b0;
        base = 0;
        for (int c = 0; c < 20 && !seen_low; c++) begin
            if (q.size() <= 10) begin
                cyc(1'b0, 1'b0, 6'h3F, mk6(base));
                base += 6;
            end else begin
                seen_low = 1'b1;
            end
        end
        chk("bp_deassert", int'(seen_low), 1);
        idle();
        chk("bp_rdy_low", obs_rdy, 0);
        drain("bp_drain");
        idle();
        chk("bp_pend_end", obs_pend, 0);
        chk("bp_rdy_end", obs_rdy, 1);

        // wrap: park head/tail at 14, then enqueue five
        cyc(1'b1, 1'b0, 6'h00, '0);
        cyc(1'b0, 1'b0, 6'h3F, mk6(0));
        cyc(1'b0, 1'b0, 6'h3F, mk6(6));
        cyc(1'b0, 1'b0, 6'b000011, mk6(12));
        drain("wrap_pre");
        cyc(1'b0, 1'b0, 6'b011111, mk6(20));
`ifndef CLEAR_BYPASS_EN
        idle();
`endif
        chk("wrap_vld0", int'(obs_vld), 4'hF);
        chk("wrap_idx0", int'(obs_idx[0]), 20);
        chk("wrap_idx3", int'(obs_idx[3]), 23);
        idle();
        chk("wrap_vld1", int'(obs_vld), 1);
        chk("wrap_idx4", int'(obs_idx[0]), 24);

        // flush with a partly full buffer and a full input burst
        cyc(1'b1, 1'b0, 6'h00, '0);
        cyc(1'b0, 1'b0, 6'h3F, mk6(0));
        cyc(1'b0, 1'b0, 6'h3F, mk6(6));
        cyc(1'b0, 1'b0, 6'b011111, mk6(12));
        cyc(1'b0, 1'b1, 6'h3F, mk6(17));
`ifndef CLEAR_BYPASS_EN
        chk("flush_pend9", obs_pend, 9);
`endif
        chk("flush_vld", int'(obs_vld), 0);
        idle();
        chk("flush_pend", obs_pend, 0);
        chk("flush_rdy", obs_rdy, 1);
        chk("flush_stale", int'(obs_vld), 0);
        idle();
        chk("flush_stale2", int'(obs_vld), 0);

        // bypass mix: two pending, three new
        cyc(1'b1, 1'b0, 6'h00, '0);
        cyc(1'b0, 1'b0, 6'h3F, mk6(16));
        cyc(1'b0, 1'b0, 6'b000111, mk6(8));
`ifdef CLEAR_BYPASS_EN
        chk("mix_pend", obs_pend, 2);
        chk("mix_vld", int'(obs_vld), 4'hF);
        chk("mix_idx0", int'(obs_idx[0]), 20);
        chk("mix_idx1", int'(obs_idx[1]), 21);
        chk("mix_idx2", int'(obs_idx[2]), 8);
        chk("mix_idx3", int'(obs_idx[3]), 9);
        idle();
        chk("mix_vld1", int'(obs_vld), 1);
        chk("mix_idx10", int'(obs_idx[0]), 10);
`endif
        drain("mix_drain");
        idle();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
